ppl_wb: RTL and testbench

PPL_WB -- requirements
Module: ppl_wb

---
 rtl/ppl_wb.sv | 185 ++++++++++++++++++
 tb/tb_ppl_wb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppl_wb.sv
// Pixel write-back: texture fetch, framebuffer write FIFO and frame FSM; PPL_WB_STATS_EN adds per-frame pixel count.
// Latency: accepted pixel reaches the FIFO head 2 cycles later; fb write as soon as fb_ready allows.
// Backpressure: fb_ready stalls the FIFO; a pixel arriving on a full FIFO is dropped and sets sticky overflow.

module ppl_wb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          wr_en;
    logic          rd_en;

    // A pop frees the slot in the same cycle, so push on full succeeds alongside it.
    assign wr_en   = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module ppl_wb #(
    parameter int H_DISP     = 1280,
    parameter int V_DISP     = 720,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_ppl,
    input  logic        rst,
    input  logic        valid,
    input  logic        vs,
    input  logic [19:0] pixel_addr,
    input  logic [12:0] texture_addr,
    output logic [12:0] tex_addr,
    input  logic [15:0] tex_data,
    output logic        fb_valid,
    input  logic        fb_ready,
    output logic [19:0] fb_addr,
    output logic [15:0] fb_data,
    output logic        frame_done,
    output logic        overflow,
    output logic [19:0] pix_cnt
);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_RUN    = 2'd1;
    localparam logic [1:0]  ST_FLUSH  = 2'd2;
    localparam logic [20:0] PIX_LIMIT = 21'(H_DISP * V_DISP);

    logic [1:0]  state;
    logic [1:0]  rst_sync;
    logic        vs_q;
    logic        vs_rise;
    logic        capture;
    logic        s1_vld;
    logic [19:0] s1_addr;
    logic        s2_vld;
    logic [19:0] s2_addr;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic [35:0] head;
    logic        pipe_empty;

    // Assertion is immediate; release only enables capture two edges later.
    always_ff @(posedge clk_ppl or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign vs_rise    = vs && !vs_q;
    assign capture    = valid && rst_sync[1] && (state != ST_IDLE);
    assign pipe_empty = !s1_vld && !s2_vld && fifo_empty;
    assign frame_done = (state == ST_FLUSH) && pipe_empty;
    assign pop        = fb_valid && fb_ready;

    always_ff @(posedge clk_ppl or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            vs_q  <= 1'b0;
        end else begin
            vs_q <= vs;
            case (state)
                ST_IDLE:  if (vs_rise)    state <= ST_RUN;
                ST_RUN:   if (vs_rise)    state <= ST_FLUSH;
                ST_FLUSH: if (pipe_empty) state <= ST_RUN;
                default:                  state <= ST_IDLE;
            endcase
        end
    end

    // S1 presents the texel address; S2 lines up with the ROM's one-cycle return.
    always_ff @(posedge clk_ppl or negedge rst) begin
        if (!rst) begin
            tex_addr <= '0;
            s1_vld   <= 1'b0;
            s1_addr  <= '0;
            s2_vld   <= 1'b0;
            s2_addr  <= '0;
            overflow <= 1'b0;
        end else begin
            s1_vld <= capture;
            if (capture) begin
                tex_addr <= texture_addr;
                s1_addr  <= pixel_addr;
            end
            s2_vld  <= s1_vld && ({1'b0, s1_addr} < PIX_LIMIT);
            s2_addr <= s1_addr;
            if (s2_vld && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    ppl_wb_fifo #(
        .W     (36),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_ppl),
        .rst_n    (rst),
        .push     (s2_vld),
        .push_dat ({s2_addr, tex_data}),
        .pop      (pop),
        .pop_dat  (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign fb_valid = !fifo_empty;
    assign fb_addr  = fifo_empty ? 20'd0 : head[35:16];
    assign fb_data  = fifo_empty ? 16'd0 : head[15:0];

`ifdef PPL_WB_STATS_EN
    logic [19:0] frame_cnt;
    logic [19:0] pix_cnt_q;

    always_ff @(posedge clk_ppl or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            pix_cnt_q <= '0;
        end else if (frame_done) begin
            pix_cnt_q <= frame_cnt;
            frame_cnt <= {19'd0, pop};
        end else if (pop && (frame_cnt != '1)) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign pix_cnt = pix_cnt_q;
`else
    assign pix_cnt = '0;
`endif
endmodule

// File: tb/tb_ppl_wb.sv
// Directed bench for ppl_wb: texture ROM model, fb write monitor, immediate-assertion checks.
module tb_ppl_wb;
`ifdef PPL_WB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_ppl = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        vs = 1'b0;
    logic [19:0] pixel_addr = '0;
    logic [12:0] texture_addr = '0;
    logic [12:0] tex_addr;
    logic [15:0] tex_data = '0;
    logic        fb_valid;
    logic        fb_ready = 1'b0;
    logic [19:0] fb_addr;
    logic [15:0] fb_data;
    logic        frame_done;
    logic        overflow;
    logic [19:0] pix_cnt;

    int checks = 0;
    int errors = 0;
    logic [35:0] wr_q [$];

    ppl_wb dut (
        .clk_ppl      (clk_ppl),
        .rst          (rst),
        .valid        (valid),
        .vs           (vs),
        .pixel_addr   (pixel_addr),
        .texture_addr (texture_addr),
        .tex_addr     (tex_addr),
        .tex_data     (tex_data),
        .fb_valid     (fb_valid),
        .fb_ready     (fb_ready),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .pix_cnt      (pix_cnt)
    );

    always #5 clk_ppl = ~clk_ppl;

    always @(posedge clk_ppl) tex_data <= 16'hF000 + {3'b000, tex_addr};

    always @(negedge clk_ppl) begin
        if (fb_valid && fb_ready) wr_q.push_back({fb_addr, fb_data});
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_ppl);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [19:0] pa, input logic [12:0] ta);
        valid        = 1'b1;
        pixel_addr   = pa;
        texture_addr = ta;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        int fd;
        bit seen3;

        tick(3);
        chk("rst_fb_valid", fb_valid, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_fb_data", fb_data, 0);
        chk("rst_tex_addr", tex_addr, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_pix_cnt", pix_cnt, 0);
        rst = 1'b1;
        tick(3);

        // basic 4-pixel stream
        fb_ready = 1'b1;
        vs = 1'b1;
        tick();
        vs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid        = 1'b1;
            pixel_addr   = 20'(i);
            texture_addr = 13'(10 + i);
            tick();
            if (i == 0) chk("s1_tex_addr", tex_addr, 10);
            if (i == 1) chk("lat_not_yet", fb_valid, 0);
            if (i == 2) begin
                chk("lat_fb_valid", fb_valid, 1);
                chk("lat_head", {fb_addr, fb_data}, {20'd0, 16'hF00A});
            end
        end
        valid = 1'b0;
        tick(6);
        chk("basic_writes", wr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("basic_entry", wr_q[i], {20'(i), 16'hF00A + 16'(i)});
        wr_q.delete();

        // address range boundary
        send(20'd921600, 13'd5);
        tick(5);
        chk("oob_writes", wr_q.size(), 0);
        chk("oob_overflow", overflow, 0);
        send(20'd921599, 13'd5);
        tick(5);
        chk("last_writes", wr_q.size(), 1);
        chk("last_entry", wr_q[0], {20'd921599, 16'hF005});
        wr_q.delete();

        // overflow with fb stalled
        fb_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid        = 1'b1;
            pixel_addr   = 20'(100 + i);
            texture_addr = 13'(i);
            tick();
        end
        valid = 1'b0;
        tick(3);
        chk("ovf_fb_valid", fb_valid, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", {fb_addr, fb_data}, {20'd100, 16'hF000});
        tick(5);
        chk("ovf_head_stable", {fb_addr, fb_data}, {20'd100, 16'hF000});
        chk("ovf_no_writes", wr_q.size(), 0);
        fb_ready = 1'b1;
        tick(25);
        chk("ovf_writes", wr_q.size(), 16);
        chk("ovf_first", wr_q[0], {20'd100, 16'hF000});
        chk("ovf_last", wr_q[15], {20'd115, 16'hF00F});
        chk("ovf_sticky", overflow, 1);
        chk("ovf_drained", fb_valid, 0);

        // frame boundary with nothing pending
        vs = 1'b1;
        tick();
        chk("empty_flush_done", frame_done, 1);
        vs = 1'b0;
        tick();
        chk("empty_flush_pulse", frame_done, 0);
        chk("pix_cnt_21", pix_cnt, STATS ? 36'd21 : 36'd0);
        wr_q.delete();

        // flush with 3 buffered pixels and toggling ready
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(20'(200 + i), 13'(20 + i));
        tick(3);
        vs = 1'b1;
        tick();
        vs = 1'b0;
        chk("flush_wait", frame_done, 0);
        fd = 0;
        seen3 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            fb_ready = (c % 2 == 1);
            tick();
            if (frame_done) fd++;
            if (wr_q.size() == 3 && !seen3) begin
                seen3 = 1'b1;
                chk("done_after_3rd_pop", frame_done, 1);
            end
        end
        chk("flush_done_count", fd, 1);
        chk("flush_writes", wr_q.size(), 3);
        chk("pix_cnt_3", pix_cnt, STATS ? 36'd3 : 36'd0);
        wr_q.delete();

        // vs edge during flush is ignored
        fb_ready = 1'b0;
        send(20'd300, 13'd1);
        send(20'd301, 13'd2);
        tick(3);
        vs = 1'b1;
        tick();
        vs = 1'b0;
        tick();
        vs = 1'b1;
        tick();
        vs = 1'b0;
        fd = 0;
        fb_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (frame_done) fd++;
        end
        chk("dbl_vs_done_count", fd, 1);
        chk("dbl_vs_writes", wr_q.size(), 2);
        chk("pix_cnt_2", pix_cnt, STATS ? 36'd2 : 36'd0);
        wr_q.delete();

        // reset with buffered entries
        fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(20'(400 + i), 13'(i));
        tick(3);
        chk("pre_rst_fb_valid", fb_valid, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_fb_valid", fb_valid, 0);
        chk("async_rst_fb_addr", fb_addr, 0);
        chk("async_rst_overflow", overflow, 0);
        tick(2);
        fb_ready = 1'b1;
        rst = 1'b1;
        tick(10);
        chk("post_rst_writes", wr_q.size(), 0);
        send(20'd7, 13'd3);
        tick(5);
        chk("idle_ignored_tex", tex_addr, 0);
        chk("idle_ignored_writes", wr_q.size(), 0);
        vs = 1'b1;
        tick();
        vs = 1'b0;
        send(20'd7, 13'd3);
        tick(5);
        chk("post_rst_run_writes", wr_q.size(), 1);
        chk("post_rst_run_entry", wr_q[0], {20'd7, 16'hF003});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
